// File: rtl/seq_decoder_scan.sv
// ---------------------------------------------------------------------------
// seq_decoder_scan
//   Registered 1-of-2**SEL_W decoder with enable. Two modes:
//     DIRECT : y shows onehot(sel) one cycle after sel is presented.
//     SCAN   : y walks through every output, each held for DWELL cycles,
//              for display-digit / row-select multiplexing.
//
// Parameters
//   SEL_W      select width, output width N = 2**SEL_W (1..5)
//   DWELL      cycles each output stays active in SCAN (>= 1)
//   ACTIVE_LOW 1: active output is 0, inactive outputs are 1
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   en     in   enable; 0 forces all outputs inactive
//   mode   in   0 = DIRECT, 1 = SCAN
//   sel    in   DIRECT: index to decode; SCAN: start index when ld=1
//   ld     in   SCAN only: load sel into idx and restart the dwell count
//   y      out  registered one-hot enable lines
//   idx    out  index currently shown on y
//   valid  out  y carries an active output
//   wrap   out  one-cycle pulse when SCAN idx advances N-1 -> 0
// ---------------------------------------------------------------------------
module seq_decoder_scan #(
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned DWELL      = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      ld,
   output logic [(1 << SEL_W)-1:0]   y,
   output logic [SEL_W-1:0]          idx,
   output logic                      valid,
   output logic                      wrap
);

   localparam int unsigned N    = 1 << SEL_W;
   localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [N-1:0]     INACTIVE   = {N{ACTIVE_LOW}};
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(N - 1);

   // Elaboration-time parameter sanity
   if (SEL_W < 1 || SEL_W > 5) begin : g_bad_sel_w
      $error("seq_decoder_scan: SEL_W must be 1..5");
   end
   if (DWELL < 1) begin : g_bad_dwell
      $error("seq_decoder_scan: DWELL must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [DW_W-1:0]   dwell, dwell_n;
   logic [SEL_W-1:0]  idx_n;
   logic [N-1:0]      y_n;
   logic              valid_n;
   logic              wrap_n;

   // One-hot decode with output polarity applied
   function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] i);
      logic [N-1:0] oh;
      oh = N'(1) << i;
      return ACTIVE_LOW ? ~oh : oh;
   endfunction

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         dwell <= '0;
         idx   <= '0;
         y     <= INACTIVE;
         valid <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         state <= state_n;
         dwell <= dwell_n;
         idx   <= idx_n;
         y     <= y_n;
         valid <= valid_n;
         wrap  <= wrap_n;
      end
   end

   // Next-state and next-output logic; priority: en, mode, ld, entry, dwell
   always_comb begin
      state_n = state;
      dwell_n = '0;
      idx_n   = idx;
      y_n     = INACTIVE;
      valid_n = 1'b0;
      wrap_n  = 1'b0;

      if (!en) begin
         // idx holds so a re-enabled scan resumes where it stopped
         state_n = IDLE;
      end else if (!mode) begin
         state_n = DIRECT;
         idx_n   = sel;
         y_n     = decode(sel);
         valid_n = 1'b1;
      end else begin
         state_n = SCAN;
         valid_n = 1'b1;
         if (ld) begin
            // load wins over a due advance in the same cycle
            idx_n = sel;
         end else if (state != SCAN) begin
            // entry cycle counts as dwell 0 of the current idx
            idx_n = idx;
         end else if (dwell == DWELL_LAST) begin
            idx_n  = idx + SEL_W'(1);
            wrap_n = (idx == IDX_LAST);
         end else begin
            dwell_n = dwell + DW_W'(1);
         end
         y_n = decode(idx_n);
      end
   end

endmodule

// File: tb/tb_seq_decoder_scan.sv
module tb_seq_decoder_scan;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // DUT1: SEL_W=2, DWELL=3, active high
   logic       en1, mode1, ld1;
   logic [1:0] sel1;
   logic [3:0] y1;
   logic [1:0] idx1;
   logic       valid1, wrap1;

   // DUT2: SEL_W=3, DWELL=1, active low
   logic       en2, mode2, ld2;
   logic [2:0] sel2;
   logic [7:0] y2;
   logic [2:0] idx2;
   logic       valid2, wrap2;

   seq_decoder_scan #(.SEL_W(2), .DWELL(3), .ACTIVE_LOW(1'b0)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .mode(mode1), .sel(sel1), .ld(ld1),
      .y(y1), .idx(idx1), .valid(valid1), .wrap(wrap1)
   );

   seq_decoder_scan #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut2 (
      .clk(clk), .rst(rst), .en(en2), .mode(mode2), .sel(sel2), .ld(ld2),
      .y(y2), .idx(idx2), .valid(valid2), .wrap(wrap2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       mode;
      logic       ld;
      logic [1:0] sel;
      logic [3:0] y;
      logic [1:0] idx;
      logic       valid;
      logic       wrap;
   } vec_t;

   typedef struct {
      int         dut;
      int         id;
      logic [7:0] y;
      logic [2:0] idx;
      logic       valid;
      logic       wrap;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic e, input logic m, input logic l, input logic [1:0] s,
                      input logic [3:0] ey, input logic [1:0] ei, input logic ev, input logic ew);
      vec_t v;
      v.en = e; v.mode = m; v.ld = l; v.sel = s;
      v.y = ey; v.idx = ei; v.valid = ev; v.wrap = ew;
      tbl.push_back(v);
   endtask

   task automatic check_now(input int dut, input int id, input logic [7:0] ey,
                            input logic [2:0] ei, input logic ev, input logic ew);
      logic [7:0] ay;
      logic [2:0] ai;
      logic       av, aw;
      if (dut == 1) begin
         ay = {4'b0000, y1}; ai = {1'b0, idx1}; av = valid1; aw = wrap1;
      end else begin
         ay = y2; ai = idx2; av = valid2; aw = wrap2;
      end
      checks++;
      if (ay !== ey || ai !== ei || av !== ev || aw !== ew) begin
         errors++;
         $display("FAIL dut%0d step %0d: got y=%b idx=%0d valid=%b wrap=%b, want y=%b idx=%0d valid=%b wrap=%b",
                  dut, id, ay, ai, av, aw, ey, ei, ev, ew);
      end
   endtask

   task automatic check_pop();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue, want an expected entry");
      end else begin
         e = sb.pop_front();
         check_now(e.dut, e.id, e.y, e.idx, e.valid, e.wrap);
      end
   endtask

   task automatic push_exp(input int dut, input int id, input logic [7:0] ey,
                           input logic [2:0] ei, input logic ev, input logic ew);
      exp_t e;
      e.dut = dut; e.id = id; e.y = ey; e.idx = ei; e.valid = ev; e.wrap = ew;
      sb.push_back(e);
   endtask

   initial begin
      logic [7:0] oh;
      logic [2:0] k3;

      en1 = 1'b0; mode1 = 1'b0; ld1 = 1'b0; sel1 = 2'd0;
      en2 = 1'b0; mode2 = 1'b0; ld2 = 1'b0; sel2 = 3'd0;

      //   en mode ld sel   y       idx  v  w
      add(0, 0, 0, 2'd0, 4'b0000, 2'd0, 0, 0);
      add(0, 0, 0, 2'd3, 4'b0000, 2'd0, 0, 0);
      add(1, 0, 0, 2'd0, 4'b0001, 2'd0, 1, 0);
      add(1, 0, 0, 2'd1, 4'b0010, 2'd1, 1, 0);
      add(1, 0, 0, 2'd2, 4'b0100, 2'd2, 1, 0);
      add(1, 0, 0, 2'd3, 4'b1000, 2'd3, 1, 0);
      add(0, 0, 0, 2'd1, 4'b0000, 2'd3, 0, 0);
      add(1, 0, 1, 2'd2, 4'b0100, 2'd2, 1, 0);
      add(1, 1, 1, 2'd2, 4'b0100, 2'd2, 1, 0);
      add(1, 1, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
      add(1, 1, 0, 2'd1, 4'b0100, 2'd2, 1, 0);
      add(1, 1, 0, 2'd3, 4'b1000, 2'd3, 1, 0);
      add(1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);
      add(1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);
      add(1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 1);
      add(1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 0);
      add(1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 0);
      add(1, 1, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
      add(1, 1, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
      add(1, 1, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
      // advance due here; load must win, no stop at idx 2
      add(1, 1, 1, 2'd3, 4'b1000, 2'd3, 1, 0);
      add(1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);
      add(1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);
      add(1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 1);
      // SCAN -> DIRECT, then back to SCAN without ld
      add(1, 0, 0, 2'd1, 4'b0010, 2'd1, 1, 0);
      add(1, 1, 0, 2'd2, 4'b0010, 2'd1, 1, 0);
      add(1, 1, 0, 2'd2, 4'b0010, 2'd1, 1, 0);
      add(1, 1, 0, 2'd2, 4'b0010, 2'd1, 1, 0);
      add(1, 1, 0, 2'd2, 4'b0100, 2'd2, 1, 0);
      add(0, 1, 0, 2'd0, 4'b0000, 2'd2, 0, 0);
      add(1, 1, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
      add(1, 1, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
      add(1, 1, 1, 2'd1, 4'b0010, 2'd1, 1, 0);
      add(1, 1, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
      // position at idx 3 with advance (and wrap) due on the next edge
      add(1, 1, 1, 2'd3, 4'b1000, 2'd3, 1, 0);
      add(1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);
      add(1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);

      // Reset values while rst is held
      #12;
      check_now(1, 900, 8'h00, 3'd0, 1'b0, 1'b0);
      check_now(2, 900, 8'hFF, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         en1 = tbl[i].en; mode1 = tbl[i].mode; ld1 = tbl[i].ld; sel1 = tbl[i].sel;
         push_exp(1, i, {4'b0000, tbl[i].y}, {1'b0, tbl[i].idx}, tbl[i].valid, tbl[i].wrap);
         @(posedge clk);
         #1;
         check_pop();
      end

      // Asynchronous reset just before the edge that would wrap
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_now(1, 901, 8'h00, 3'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_now(1, 902, 8'h00, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      en1 = 1'b0; mode1 = 1'b0; ld1 = 1'b0;
      push_exp(1, 903, 8'h00, 3'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_pop();

      // Active-low, DWELL=1, 8 outputs: one step per cycle
      @(negedge clk);
      en2 = 1'b1; mode2 = 1'b1; ld2 = 1'b1; sel2 = 3'd0;
      push_exp(2, 0, 8'b1111_1110, 3'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check_pop();
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         ld2 = 1'b0;
         sel2 = 3'(k);
         k3 = 3'(k % 8);
         oh = 8'd1 << k3;
         push_exp(2, k, ~oh, k3, 1'b1, (k3 == 3'd0));
         @(posedge clk);
         #1;
         check_pop();
      end
      @(negedge clk);
      en2 = 1'b0;
      push_exp(2, 18, 8'hFF, 3'd1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_pop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
